// File: rtl/uctl_cc_pkg.sv
// Shared definitions for the client-memory arbiter.
// Contents:
//   NUM_CL / CL_IDX_W  number of clients and width of a client index
//   arb_state_t        arbiter state encoding
//   ONEHOT()           client index -> one-hot client vector
package uctl_cc_pkg;

    localparam int unsigned NUM_CL   = 4;
    localparam int unsigned CL_IDX_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BURST  = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_t;

    function automatic logic [NUM_CL-1:0] ONEHOT(input logic [CL_IDX_W-1:0] idx);
        logic [NUM_CL-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/uctl_rr_pick.sv
// Combinational 4-way rotate-priority picker.
// Ports:
//   req  in  NUM_CL    request vector
//   ptr  in  CL_IDX_W  highest-priority client index for this pick
//   mask in  NUM_CL    clients eligible for this pick
//   gnt  out NUM_CL    one-hot winner (or 0)
//   vld  out 1         a winner exists
//   idx  out CL_IDX_W  index of the winner (0 when vld=0)
module uctl_rr_pick
    import uctl_cc_pkg::*;
(
    input  logic [NUM_CL-1:0]   req,
    input  logic [CL_IDX_W-1:0] ptr,
    input  logic [NUM_CL-1:0]   mask,
    output logic [NUM_CL-1:0]   gnt,
    output logic                vld,
    output logic [CL_IDX_W-1:0] idx
);

    logic [NUM_CL-1:0]   cand;
    logic [CL_IDX_W-1:0] pos;

    always_comb begin
        cand = req & mask;
        vld  = 1'b0;
        idx  = '0;
        pos  = '0;
        // Scan ptr, ptr+1, ... wrapping naturally in CL_IDX_W bits.
        for (int unsigned k = 0; k < NUM_CL; k++) begin
            pos = ptr + CL_IDX_W'(k);
            if (!vld && cand[pos]) begin
                vld = 1'b1;
                idx = pos;
            end
        end
        gnt = vld ? ONEHOT(idx) : '0;
    end

endmodule

// File: rtl/uctl_cc_arbiter.sv
// Round-robin arbiter sharing the single-port client memory between 4
// clients. Grants are combinational from registered state so the access
// happens in the grant cycle. Each owner may keep the grant for up to
// MAX_BURST beats while others wait; a client may lock the arbiter, and
// a lock idle for LOCK_TMO cycles is forcibly released.
// Ports:
//   uctl_clk        in   1  block clock
//   uctl_core_rst   in   1  asynchronous active-high reset
//   uctl_clReq      in   4  per-client access request
//   uctl_clLock     in   4  per-client lock request (sampled on granted cycles)
//   uctl_chipsel    out  4  one-hot grant or 0 to the cc mux (no latency)
//   uctl_owner      out  2  registered index of current/last owner
//   uctl_arbLocked  out  1  registered, high while locked
//   uctl_lockTmo    out  1  registered one-cycle pulse on forced lock release
module uctl_cc_arbiter
    import uctl_cc_pkg::*;
#(
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned LOCK_TMO  = 64,
    parameter int unsigned CNT_W     = $clog2(LOCK_TMO + 1)
) (
    input  logic                uctl_clk,
    input  logic                uctl_core_rst,
    input  logic [NUM_CL-1:0]   uctl_clReq,
    input  logic [NUM_CL-1:0]   uctl_clLock,
    output logic [NUM_CL-1:0]   uctl_chipsel,
    output logic [CL_IDX_W-1:0] uctl_owner,
    output logic                uctl_arbLocked,
    output logic                uctl_lockTmo
);

    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TMO - 1);

    arb_state_t          state, state_n;
    logic [CL_IDX_W-1:0] ptr, ptr_n;
    logic [CL_IDX_W-1:0] owner, owner_n;
    logic [CNT_W-1:0]    beat_cnt, beat_n;
    logic [CNT_W-1:0]    tmo_cnt, tmo_n;
    logic                lock_tmo_q, lock_tmo_n;
    logic                locked_q;
    logic [NUM_CL-1:0]   chipsel_c;

    logic [NUM_CL-1:0]   own_oh;
    logic                owner_req;
    logic                others_req;

    logic [CL_IDX_W-1:0] pick_ptr;
    logic [NUM_CL-1:0]   pick_mask;
    logic [NUM_CL-1:0]   pick_gnt;
    logic                pick_vld;
    logic [CL_IDX_W-1:0] pick_idx;

    assign own_oh     = ONEHOT(owner);
    assign owner_req  = uctl_clReq[owner];
    assign others_req = |(uctl_clReq & ~own_oh);

    // Picker inputs depend only on registered state, keeping the shared
    // picker out of any combinational loop with the decision logic.
    always_comb begin
        pick_ptr  = ptr;
        pick_mask = '1;
        case (state)
            ST_BURST: begin
                pick_ptr  = owner + 1'b1;
                pick_mask = (beat_cnt == BURST_MAX) ? ~own_oh : '1;
            end
            ST_LOCKED: begin
                pick_ptr  = owner + 1'b1;
                pick_mask = ~own_oh;
            end
            default: begin
                pick_ptr  = ptr;
                pick_mask = '1;
            end
        endcase
    end

    uctl_rr_pick u_pick (
        .req  (uctl_clReq),
        .ptr  (pick_ptr),
        .mask (pick_mask),
        .gnt  (pick_gnt),
        .vld  (pick_vld),
        .idx  (pick_idx)
    );

    always_comb begin
        logic take_pick;

        state_n    = state;
        ptr_n      = ptr;
        owner_n    = owner;
        beat_n     = beat_cnt;
        tmo_n      = tmo_cnt;
        lock_tmo_n = 1'b0;
        chipsel_c  = '0;
        take_pick  = 1'b0;

        case (state)
            ST_IDLE: begin
                take_pick = 1'b1;
            end

            ST_BURST: begin
                if (owner_req && (beat_cnt < BURST_MAX || !others_req)) begin
                    chipsel_c = own_oh;
                    if (beat_cnt < BURST_MAX) begin
                        beat_n = beat_cnt + 1'b1;
                    end
                    if (uctl_clLock[owner]) begin
                        state_n = ST_LOCKED;
                        tmo_n   = '0;
                    end
                end else begin
                    take_pick = 1'b1;
                end
            end

            ST_LOCKED: begin
                if (owner_req) begin
                    chipsel_c = own_oh;
                    tmo_n     = '0;
                    if (!uctl_clLock[owner]) begin
                        state_n = ST_BURST;
                        beat_n  = CNT_W'(1);
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    take_pick  = 1'b1;
                    lock_tmo_n = 1'b1;
                    tmo_n      = '0;
                end else if (tmo_cnt != '1) begin
                    tmo_n = tmo_cnt + 1'b1;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Rearbitration shared by IDLE, burst hand-over and forced release.
        if (take_pick) begin
            if (pick_vld) begin
                chipsel_c = pick_gnt;
                owner_n   = pick_idx;
                ptr_n     = pick_idx + 1'b1;
                beat_n    = CNT_W'(1);
                tmo_n     = '0;
                state_n   = uctl_clLock[pick_idx] ? ST_LOCKED : ST_BURST;
            end else begin
                state_n = ST_IDLE;
                if (state != ST_IDLE) begin
                    ptr_n = owner + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge uctl_clk or posedge uctl_core_rst) begin
        if (uctl_core_rst) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            owner      <= '0;
            beat_cnt   <= '0;
            tmo_cnt    <= '0;
            lock_tmo_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            owner      <= owner_n;
            beat_cnt   <= beat_n;
            tmo_cnt    <= tmo_n;
            lock_tmo_q <= lock_tmo_n;
            locked_q   <= (state_n == ST_LOCKED);
        end
    end

    // Grant is gated by reset so it drops asynchronously with the state.
    assign uctl_chipsel   = uctl_core_rst ? '0 : chipsel_c;
    assign uctl_owner     = owner;
    assign uctl_arbLocked = locked_q;
    assign uctl_lockTmo   = lock_tmo_q;

endmodule

// File: tb/tb_uctl_cc_arbiter.sv
// Directed and constrained-random bench for uctl_cc_arbiter.
module tb_uctl_cc_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] chipsel;
    logic [1:0] owner;
    logic       arb_locked;
    logic       lock_tmo;

    int checks = 0;
    int errors = 0;

    uctl_cc_arbiter #(.MAX_BURST(8), .LOCK_TMO(64)) dut (
        .uctl_clk       (clk),
        .uctl_core_rst  (rst),
        .uctl_clReq     (req),
        .uctl_clLock    (lock),
        .uctl_chipsel   (chipsel),
        .uctl_owner     (owner),
        .uctl_arbLocked (arb_locked),
        .uctl_lockTmo   (lock_tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic cyc(input logic [3:0] r, input logic [3:0] l);
        @(negedge clk);
        req  = r;
        lock = l;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        req  = '0;
        lock = '0;
        @(negedge clk);
        rst  = 1'b0;
    endtask

    logic [3:0] exp_oh;
    logic [3:0] rq, lk;
    int         waits [4];
    logic       ok;

    initial begin
        rst  = 1'b1;
        req  = '0;
        lock = '0;
        #1;
        req  = 4'hF;
        #1;
        check("rst_chipsel", chipsel, 4'h0);
        check("rst_owner", owner, 2'd0);
        check("rst_locked", arb_locked, 1'b0);
        check("rst_tmo", lock_tmo, 1'b0);
        req = '0;

        // Full contention: 8 beats per client in order 0,1,2,3,0
        do_reset();
        for (int k = 0; k < 40; k++) begin
            cyc(4'hF, 4'h0);
            exp_oh = 4'b0001 << ((k / 8) % 4);
            check("rr_burst", chipsel, exp_oh);
        end

        // Lone requester keeps the grant; cl0 takes over once beat_cnt is at max
        do_reset();
        for (int k = 0; k < 20; k++) begin
            cyc(4'b0100, 4'h0);
            check("solo_cl2", chipsel, 4'b0100);
        end
        cyc(4'b0101, 4'h0);
        check("solo_switch", chipsel, 4'b0001);
        cyc(4'b0001, 4'h0);
        check("solo_cl0_gnt", chipsel, 4'b0001);
        check("solo_cl0_owner", owner, 2'd0);

        // cl1 locks; cl3 starves while locked, then wins after release
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cyc(4'b1010, 4'b0010);
            check("lock_beat", chipsel, 4'b0010);
            if (k > 0) check("lock_flag", arb_locked, 1'b1);
        end
        for (int k = 0; k < 10; k++) begin
            cyc(4'b1000, 4'b0010);
            check("lock_hold", chipsel, 4'b0000);
        end
        cyc(4'b1010, 4'b0000);
        check("lock_release_gnt", chipsel, 4'b0010);
        check("lock_release_flag", arb_locked, 1'b1);
        cyc(4'b1000, 4'b0000);
        check("after_lock_cl3", chipsel, 4'b1000);
        check("after_lock_flag", arb_locked, 1'b0);

        // Lock timeout: cl0 locks then goes idle while cl1 requests
        do_reset();
        cyc(4'b0011, 4'b0001);
        check("tmo_lock_gnt", chipsel, 4'b0001);
        for (int j = 1; j <= 64; j++) begin
            cyc(4'b0010, 4'b0000);
            check("tmo_wait", chipsel, (j == 64) ? 4'b0010 : 4'b0000);
            check("tmo_pulse_lo", lock_tmo, 1'b0);
        end
        check("tmo_still_locked", arb_locked, 1'b1);
        cyc(4'b0010, 4'b0000);
        check("tmo_pulse", lock_tmo, 1'b1);
        check("tmo_unlocked", arb_locked, 1'b0);
        check("tmo_owner", owner, 2'd1);
        check("tmo_cl1_cont", chipsel, 4'b0010);
        cyc(4'b0010, 4'b0000);
        check("tmo_pulse_once", lock_tmo, 1'b0);

        // Asynchronous reset in the middle of a burst
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cyc(4'b0100, 4'h0);
            check("pre_rst_gnt", chipsel, 4'b0100);
        end
        check("pre_rst_owner", owner, 2'd2);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_chipsel", chipsel, 4'b0000);
        check("async_rst_owner", owner, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(4'b1000, 4'h0);
        check("post_rst_gnt", chipsel, 4'b1000);
        cyc(4'b1000, 4'h0);
        check("post_rst_owner", owner, 2'd3);

        // Random traffic: clients hold req until granted
        do_reset();
        rq = '0;
        lk = '0;
        for (int i = 0; i < 4; i++) waits[i] = 0;
        for (int n = 0; n < 10000; n++) begin
            cyc(rq, lk);
            ok = ($countones(chipsel) <= 1) && ((chipsel & ~rq) == 4'h0);
            check("rand_legal", ok, 1'b1);
            ok = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (arb_locked) waits[i] = 0;
                else if (rq[i] && !chipsel[i]) waits[i]++;
                else waits[i] = 0;
                if (waits[i] > 25) ok = 1'b0;
            end
            check("rand_wait", ok, 1'b1);
            for (int i = 0; i < 4; i++) begin
                if (rq[i] && chipsel[i]) rq[i] = ($urandom_range(0, 2) != 0);
                else if (!rq[i])         rq[i] = ($urandom_range(0, 3) == 0);
                lk[i] = ($urandom_range(0, 15) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
